// File: rtl/dram_rd_arbiter.sv
// Two-port arbiter for the shared DRAM read command channel: one outstanding
// read at a time, with returned burst beats steered to the port that owns the read.
module dram_rd_arbiter #(
  parameter int PRIO0        = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  s_kick,
  input  logic [31:0] s_addr0,
  input  logic [31:0] s_addr1,
  input  logic [31:0] s_num0,
  input  logic [31:0] s_num1,
  output logic [1:0]  s_busy,
  output logic [1:0]  s_buf_we,
  output logic [31:0] s_buf_dout,
  output logic        kick,
  output logic [31:0] read_addr,
  output logic [31:0] read_num,
  input  logic        busy,
  input  logic [31:0] buf_dout,
  input  logic        buf_we,
  output logic        owner,
  output logic [15:0] stray_cnt
);

  localparam bit       PRIO_MODE  = (PRIO0 != 0);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] starve_cnt_r;
  logic       win_s;
  logic [7:0] starve_nxt_s;
  logic       active_s;

  // Winner selection; owner doubles as the last-granted index for round-robin.
  always_comb begin
    win_s = 1'b0;
    if (s_kick == 2'b11) begin
      if (PRIO_MODE) begin
        win_s = (starve_cnt_r >= STARVE_MAX);
      end else begin
        win_s = ~owner;
      end
    end else begin
      win_s = s_kick[1];
    end
  end

  // Starvation counter next value, applied at grant time.
  always_comb begin
    starve_nxt_s = starve_cnt_r;
    if (!PRIO_MODE) begin
      starve_nxt_s = 8'd0;
    end else if (win_s) begin
      starve_nxt_s = 8'd0;
    end else if (s_kick[1] && (starve_cnt_r < STARVE_MAX)) begin
      starve_nxt_s = starve_cnt_r + 8'd1;
    end else begin
      starve_nxt_s = starve_cnt_r;
    end
  end

  // Command sequencer: IDLE -> GRANT (kick held until busy) -> RUN (wait busy low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      kick         <= 1'b0;
      read_addr    <= 32'd0;
      read_num     <= 32'd0;
      owner        <= 1'b1;
      starve_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|s_kick) begin
            read_addr    <= win_s ? s_addr1 : s_addr0;
            read_num     <= win_s ? s_num1 : s_num0;
            owner        <= win_s;
            kick         <= 1'b1;
            starve_cnt_r <= starve_nxt_s;
            state_r      <= ST_GRANT;
          end else begin
            kick    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (busy) begin
            kick    <= 1'b0;
            state_r <= ST_RUN;
          end else begin
            kick    <= 1'b1;
            state_r <= ST_GRANT;
          end
        end
        ST_RUN: begin
          kick <= 1'b0;
          if (!busy) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          kick    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Beats arriving with no read in flight are dropped and counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stray_cnt <= 16'd0;
    end else if ((state_r == ST_IDLE) && buf_we && (stray_cnt != 16'hFFFF)) begin
      stray_cnt <= stray_cnt + 16'd1;
    end else begin
      stray_cnt <= stray_cnt;
    end
  end

  assign active_s    = (state_r != ST_IDLE);
  assign s_busy      = {busy & active_s & owner, busy & active_s & ~owner};
  assign s_buf_we    = {buf_we & active_s & owner, buf_we & active_s & ~owner};
  assign s_buf_dout  = buf_dout;

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Directed bench for dram_rd_arbiter: a round-robin and a priority instance share
// stimulus; a cycle-level DRAM engine model and requester model drive both.
module tb_dram_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  s_kick = 2'b00;
  logic [31:0] s_addr0 = 32'd0, s_addr1 = 32'd0, s_num0 = 32'd0, s_num1 = 32'd0;
  logic        busy = 1'b0, buf_we = 1'b0;
  logic [31:0] buf_dout = 32'd0;
  logic        sel = 1'b0;

  logic [1:0]  rr_s_busy, rr_s_buf_we, pr_s_busy, pr_s_buf_we;
  logic [31:0] rr_s_buf_dout, pr_s_buf_dout, rr_read_addr, pr_read_addr, rr_read_num, pr_read_num;
  logic        rr_kick, pr_kick, rr_owner, pr_owner;
  logic [15:0] rr_stray_cnt, pr_stray_cnt;

  logic [1:0]  o_s_busy, o_s_buf_we;
  logic [31:0] o_s_buf_dout, o_read_addr, o_read_num;
  logic        o_kick, o_owner;
  logic [15:0] o_stray_cnt;

  assign o_s_busy     = sel ? pr_s_busy     : rr_s_busy;
  assign o_s_buf_we   = sel ? pr_s_buf_we   : rr_s_buf_we;
  assign o_s_buf_dout = sel ? pr_s_buf_dout : rr_s_buf_dout;
  assign o_read_addr  = sel ? pr_read_addr  : rr_read_addr;
  assign o_read_num   = sel ? pr_read_num   : rr_read_num;
  assign o_kick       = sel ? pr_kick       : rr_kick;
  assign o_owner      = sel ? pr_owner      : rr_owner;
  assign o_stray_cnt  = sel ? pr_stray_cnt  : rr_stray_cnt;

  dram_rd_arbiter #(.PRIO0(0), .STARVE_LIMIT(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .s_kick(s_kick),
    .s_addr0(s_addr0), .s_addr1(s_addr1), .s_num0(s_num0), .s_num1(s_num1),
    .s_busy(rr_s_busy), .s_buf_we(rr_s_buf_we), .s_buf_dout(rr_s_buf_dout),
    .kick(rr_kick), .read_addr(rr_read_addr), .read_num(rr_read_num),
    .busy(busy), .buf_dout(buf_dout), .buf_we(buf_we),
    .owner(rr_owner), .stray_cnt(rr_stray_cnt)
  );

  dram_rd_arbiter #(.PRIO0(1), .STARVE_LIMIT(3)) u_pr (
    .clk(clk), .rst_n(rst_n), .s_kick(s_kick),
    .s_addr0(s_addr0), .s_addr1(s_addr1), .s_num0(s_num0), .s_num1(s_num1),
    .s_busy(pr_s_busy), .s_buf_we(pr_s_buf_we), .s_buf_dout(pr_s_buf_dout),
    .kick(pr_kick), .read_addr(pr_read_addr), .read_num(pr_read_num),
    .busy(busy), .buf_dout(buf_dout), .buf_we(buf_we),
    .owner(pr_owner), .stray_cnt(pr_stray_cnt)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int we0_cnt, we1_cnt, sbusy_bad, dout_bad, model_we_cnt;
  int n_grant, n_fall;
  int g_own [16];
  int g_cyc [16];
  logic [31:0] g_addr [16];
  int f_cyc [16];
  int rem0, rem1;
  int m_st, m_cnt, m_delay;
  logic [31:0] m_num;
  bit inj_we, chk_en;
  int exp_port;
  logic kick_q, busy_q;

  // One clock: log grants, run the DRAM engine model, then the requesters.
  task automatic cycle();
    @(posedge clk);
    if (buf_we && rst_n) model_we_cnt++;
    #1;
    cyc++;
    if (o_kick && !kick_q && n_grant < 16) begin
      g_own[n_grant]  = int'(o_owner);
      g_addr[n_grant] = o_read_addr;
      g_cyc[n_grant]  = cyc;
      n_grant++;
    end
    kick_q = o_kick;
    buf_we = 1'b0;
    case (m_st)
      0: begin
        busy = 1'b0;
        if (o_kick) begin
          m_num = o_read_num;
          m_cnt = m_delay - 1;
          m_st  = 1;
        end else if (inj_we) begin
          buf_we = 1'b1;
        end
      end
      1: begin
        if (m_cnt == 0) begin
          busy = 1'b1;
          m_st = 2;
        end else begin
          m_cnt--;
          busy = 1'b0;
        end
      end
      default: begin
        if (m_num != 32'd0) begin
          busy     = 1'b1;
          buf_we   = 1'b1;
          buf_dout = 32'hA500_0000 + m_num;
          m_num    = m_num - 32'd1;
        end else begin
          busy = 1'b0;
          m_st = 0;
        end
      end
    endcase
    if (busy_q && !busy && n_fall < 16) begin
      f_cyc[n_fall] = cyc;
      n_fall++;
    end
    busy_q = busy;
    #1;
    if (o_s_buf_we[0]) we0_cnt++;
    if (o_s_buf_we[1]) we1_cnt++;
    if (chk_en) begin
      if (o_s_busy !== ((exp_port == 1) ? {busy, 1'b0} : {1'b0, busy})) sbusy_bad++;
      if (o_s_buf_dout !== buf_dout) dout_bad++;
    end
    if (o_kick && o_s_busy[0] && s_kick[0]) rem0--;
    if (o_kick && o_s_busy[1] && s_kick[1]) rem1--;
    s_kick = {rem1 > 0, rem0 > 0};
  endtask

  // Run until all requests are served and the model engine is idle.
  task automatic run(input int max_cyc, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!(rem0 == 0 && rem1 == 0 && m_st == 0 && !busy && !o_kick)) begin
      cycle();
      n++;
      if (n >= max_cyc) begin
        ok = 1'b0;
        break;
      end
    end
    cycle();
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    s_kick = 2'b00; busy = 1'b0; buf_we = 1'b0; inj_we = 1'b0; chk_en = 1'b0;
    rem0 = 0; rem1 = 0; m_st = 0; m_delay = 3; m_num = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    we0_cnt = 0; we1_cnt = 0; sbusy_bad = 0; dout_bad = 0; model_we_cnt = 0;
    n_grant = 0; n_fall = 0; kick_q = 1'b0; busy_q = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b1;
    reset_all();
    rst_n = 1'b0;
    #3;
    total++; if (o_kick !== 1'b0) begin bad++; $display("FAIL reset_kick got=%0h exp=0", o_kick); end
    total++; if (o_read_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", o_read_addr); end
    total++; if (o_read_num !== 32'd0) begin bad++; $display("FAIL reset_num got=%0h exp=0", o_read_num); end
    total++; if (o_owner !== 1'b1) begin bad++; $display("FAIL reset_owner got=%0h exp=1", o_owner); end
    total++; if (o_stray_cnt !== 16'd0) begin bad++; $display("FAIL reset_stray got=%0h exp=0", o_stray_cnt); end
    total++; if (o_s_busy !== 2'b00) begin bad++; $display("FAIL reset_sbusy got=%0h exp=0", o_s_busy); end
  endtask

  task automatic test_single();
    bit ok;
    sel = 1'b1;
    reset_all();
    s_addr0 = 32'h1000_0000; s_num0 = 32'd400;
    rem0 = 1; s_kick = 2'b01;
    chk_en = 1'b1; exp_port = 0;
    cycle();
    total++; if (o_kick !== 1'b1) begin bad++; $display("FAIL single_kick got=%0h exp=1", o_kick); end
    total++; if (o_read_addr !== 32'h1000_0000) begin bad++; $display("FAIL single_addr got=%0h exp=10000000", o_read_addr); end
    total++; if (o_read_num !== 32'd400) begin bad++; $display("FAIL single_num got=%0d exp=400", o_read_num); end
    total++; if (o_owner !== 1'b0) begin bad++; $display("FAIL single_owner got=%0h exp=0", o_owner); end
    run(2000, ok);
    cycle();
    chk_en = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_timeout got=%0d exp=1", ok); end
    total++; if (we0_cnt !== 400) begin bad++; $display("FAIL single_we0 got=%0d exp=400", we0_cnt); end
    total++; if (we1_cnt !== 0) begin bad++; $display("FAIL single_we1 got=%0d exp=0", we1_cnt); end
    total++; if (sbusy_bad !== 0) begin bad++; $display("FAIL single_sbusy got=%0d exp=0", sbusy_bad); end
    total++; if (dout_bad !== 0) begin bad++; $display("FAIL single_dout got=%0d exp=0", dout_bad); end
    total++; if (o_stray_cnt !== 16'd0) begin bad++; $display("FAIL single_stray got=%0d exp=0", o_stray_cnt); end
  endtask

  task automatic test_round_robin();
    bit ok;
    sel = 1'b0;
    reset_all();
    s_addr0 = 32'h1000_0000; s_addr1 = 32'h2000_0000; s_num0 = 32'd4; s_num1 = 32'd5;
    rem0 = 3; rem1 = 3; s_kick = 2'b11;
    run(2000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rr_timeout got=%0d exp=1", ok); end
    total++; if (n_grant !== 6) begin bad++; $display("FAIL rr_count got=%0d exp=6", n_grant); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (g_own[i] !== (i % 2)) begin bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, g_own[i], i % 2); end
      total++;
      if (g_addr[i] !== ((i % 2 == 1) ? 32'h2000_0000 : 32'h1000_0000)) begin
        bad++; $display("FAIL rr_addr[%0d] got=%0h exp=%0h", i, g_addr[i], (i % 2 == 1) ? 32'h2000_0000 : 32'h1000_0000);
      end
    end
  endtask

  task automatic test_priority();
    bit ok;
    logic [7:0] exp_seq;
    exp_seq = 8'b1000_1000;
    sel = 1'b1;
    reset_all();
    s_addr0 = 32'h1000_0000; s_addr1 = 32'h2000_0000; s_num0 = 32'd2; s_num1 = 32'd3;
    rem0 = 6; rem1 = 2; s_kick = 2'b11;
    run(2000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL prio_timeout got=%0d exp=1", ok); end
    total++; if (n_grant !== 8) begin bad++; $display("FAIL prio_count got=%0d exp=8", n_grant); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (g_own[i] !== int'(exp_seq[i])) begin bad++; $display("FAIL prio_order[%0d] got=%0d exp=%0d", i, g_own[i], exp_seq[i]); end
    end
  endtask

  task automatic test_turnaround();
    bit ok;
    sel = 1'b0;
    reset_all();
    s_addr0 = 32'h1000_0100; s_addr1 = 32'h2000_0200; s_num0 = 32'd6; s_num1 = 32'd2;
    rem0 = 1; rem1 = 1; s_kick = 2'b11;
    run(500, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL turn_timeout got=%0d exp=1", ok); end
    total++; if (n_grant !== 2 || n_fall < 1) begin bad++; $display("FAIL turn_count got=%0d exp=2", n_grant); end
    else begin
      total++; if (g_cyc[1] !== f_cyc[0] + 2) begin bad++; $display("FAIL turn_gap got=%0d exp=%0d", g_cyc[1], f_cyc[0] + 2); end
      total++; if (g_addr[1] !== 32'h2000_0200) begin bad++; $display("FAIL turn_addr got=%0h exp=20000200", g_addr[1]); end
    end
  endtask

  task automatic test_stray();
    sel = 1'b1;
    reset_all();
    for (int i = 0; i < 5; i++) begin
      inj_we = 1'b1; cycle();
      inj_we = 1'b0; cycle();
    end
    cycle();
    total++; if (o_stray_cnt !== 16'd5) begin bad++; $display("FAIL stray_cnt got=%0d exp=5", o_stray_cnt); end
    total++; if (we0_cnt + we1_cnt !== 0) begin bad++; $display("FAIL stray_we got=%0d exp=0", we0_cnt + we1_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    sel = 1'b1;
    reset_all();
    s_addr0 = 32'h1000_0000; s_num0 = 32'd400;
    rem0 = 1; s_kick = 2'b01;
    n = 0;
    while (we0_cnt < 100 && n < 1000) begin cycle(); n++; end
    total++; if (we0_cnt !== 100) begin bad++; $display("FAIL areset_reach got=%0d exp=100", we0_cnt); end
    rst_n = 1'b0;
    #1;
    total++; if (o_kick !== 1'b0) begin bad++; $display("FAIL areset_kick got=%0h exp=0", o_kick); end
    total++; if (o_s_busy !== 2'b00) begin bad++; $display("FAIL areset_sbusy got=%0h exp=0", o_s_busy); end
    total++; if (o_s_buf_we !== 2'b00) begin bad++; $display("FAIL areset_we got=%0h exp=0", o_s_buf_we); end
    total++; if (o_owner !== 1'b1) begin bad++; $display("FAIL areset_owner got=%0h exp=1", o_owner); end
    rem0 = 0; s_kick = 2'b00; model_we_cnt = 0;
    cycle(); cycle();
    rst_n = 1'b1;
    run(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL areset_drain got=%0d exp=1", ok); end
    total++; if (o_stray_cnt !== 16'(model_we_cnt) || model_we_cnt == 0) begin
      bad++; $display("FAIL areset_stray got=%0d exp=%0d", o_stray_cnt, model_we_cnt);
    end
    total++; if (we0_cnt !== 100) begin bad++; $display("FAIL areset_we0 got=%0d exp=100", we0_cnt); end
    s_addr1 = 32'h2000_0040; s_num1 = 32'd8;
    rem1 = 1; s_kick = 2'b10; n_grant = 0; we1_cnt = 0;
    cycle();
    total++; if (o_kick !== 1'b1 || o_owner !== 1'b1) begin bad++; $display("FAIL areset_p1_grant got=%0h/%0h exp=1/1", o_kick, o_owner); end
    total++; if (o_read_addr !== 32'h2000_0040) begin bad++; $display("FAIL areset_p1_addr got=%0h exp=20000040", o_read_addr); end
    run(500, ok);
    total++; if (ok !== 1'b1 || we1_cnt !== 8) begin bad++; $display("FAIL areset_p1_beats got=%0d exp=8", we1_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_turnaround();
    test_stray();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
